uart_xcvr_fifo: RTL
===================

Name: uart_xcvr_fifo

Overview:
Parametrised full-duplex UART transceiver; successor to the fixed 8N1 single-byte UART.
Adds configurable data width, parity, stop-bit count, a show-ahead RX FIFO with per-entry error flags, a valid/ready TX interface, glitch-rejecting start detection and an asynchronous reset.
Sits between the board UART pins and the text engine's character path.

Parameters:
CLKS_PER_BIT, 234, clock cycles per bit (27 MHz / 115200); must be at least 4.
DATA_BITS, 8, payload bits per frame; range 5..8.
PARITY_EN, 0, 1 inserts and checks a parity bit after the data bits.
PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; 1 or 2.
RX_FIFO_DEPTH, 16, RX FIFO entries; must be a power of two, at least 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  serial line in, asynchronous to clk
uart_tx  out  1  serial line out
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  transmitter can accept a byte
rx_data  out  DATA_BITS  FIFO head data
rx_frame_err  out  1  head entry had a low stop bit
rx_parity_err  out  1  head entry failed the parity check
rx_valid  out  1  FIFO is not empty
rx_ready  in  1  consumer pops the head entry
rx_overflow  out  1  one-cycle pulse when a received frame is dropped
rx_fifo_count  out  $clog2(RX_FIFO_DEPTH)+1  current number of FIFO entries

Behaviour:
- Reset (asynchronous, active-low): uart_tx=1, tx_ready=1, rx_valid=0, rx_overflow=0, rx_fifo_count=0, rx_data=0, both error flags 0.
  - RX and TX state machines go to IDLE.
  - FIFO pointers clear.
  - A frame in progress is abandoned; no partial byte is ever pushed.
- Frame format: start(0), DATA_BITS LSB-first, optional parity, STOP_BITS stop bits(1).
  - Each bit lasts exactly CLKS_PER_BIT cycles.
- TX state machine: IDLE, START, DATA, PARITY, STOP.
  - A transfer is accepted when tx_valid and tx_ready are both high; tx_data is latched on that edge.
  - uart_tx drives the start bit from the following cycle.
  - tx_ready is low from the cycle after acceptance and reasserts in the final cycle of the last stop bit.
  - Back-to-back transfers therefore have no idle gap.
  - Frame length (8N1, 234) = 10×234 = 2340 cycles.
  - Parity bit = XOR of data bits, inverted when PARITY_ODD=1.
- RX input path: uart_rx passes through a 2-FF synchroniser; all RX timing is relative to the synchronised signal.
- RX state machine: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE→START: on the first low sample.
  - START: at CLKS_PER_BIT/2 cycles the line is re-sampled.
    - If high, treat as a glitch and return to IDLE; nothing is pushed.
    - If low, proceed to DATA.
  - DATA and PARITY: each bit is sampled CLKS_PER_BIT cycles after the previous sample point (mid-bit).
  - STOP: only the first stop bit is sampled. On that sample the entry {parity_err, frame_err, data} is pushed into the FIFO.
  - After the push: if the stop sample was 1, go to IDLE; if 0 (break or framing error), go to WAIT_IDLE.
  - WAIT_IDLE: wait for a high sample, then go to IDLE.
  - With STOP_BITS=2, RX does not check the second stop bit.
- RX FIFO (show-ahead):
  - rx_data and both error flags present the head entry whenever rx_valid=1; they hold their value when the FIFO is empty.
  - A pop occurs when rx_valid and rx_ready are both high.
  - A push makes rx_valid rise on the next cycle.
  - Push when full with no pop in the same cycle: the new entry is dropped, rx_overflow pulses for 1 cycle and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both occur, rx_fifo_count is unchanged and there is no overflow.
  - Push and pop in the same cycle when empty: the push occurs and the pop is ignored, because rx_valid was 0.
  - Pointers wrap modulo RX_FIFO_DEPTH; rx_fifo_count saturates at RX_FIFO_DEPTH.
- TX and RX are fully independent; loopback (uart_tx tied to uart_rx) is a legal configuration.

Test Plan:
- Defaults, tx_data=0x4C, tx_valid pulsed 1 cycle → uart_tx low for 234 cycles, then 0,0,1,1,0,0,1,0 (LSB first), then high; tx_ready returns at cycle 2340.
- Loopback, tx_valid held high with "Lushay" (6 bytes) → no idle gaps on uart_tx; RX FIFO receives 0x4C,0x75,0x73,0x68,0x61,0x79 with no errors; rx_fifo_count=6.
- PARITY_EN=1, PARITY_ODD=0, rx frame 0x41 sent with parity bit 1 (wrong) → entry 0x41 with rx_parity_err=1 and rx_frame_err=0.
- Stop bit driven low, then line held low for 3 bit times → one entry with rx_frame_err=1; no further entries until the line returns high and a new start bit arrives.
- 100-cycle low glitch on uart_rx (less than 117) → no push and RX back in IDLE; a valid frame after it is received correctly.
- RX_FIFO_DEPTH=4, 5 frames with rx_ready=0 → count=4, one rx_overflow pulse, first 4 bytes retained; assert rst_n low mid-frame → all outputs at reset values, count=0.

Source files
------------

// File: rtl/uart_xcvr_fifo.sv
// Full-duplex UART transceiver with configurable framing, valid/ready TX
// and a show-ahead RX FIFO that carries per-entry parity/framing flags.
module uart_xcvr_fifo #(
  parameter int unsigned CLKS_PER_BIT  = 234,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY_EN     = 0,
  parameter int unsigned PARITY_ODD    = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               uart_rx,
  output logic                               uart_tx,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic [DATA_BITS-1:0]               rx_data,
  output logic                               rx_frame_err,
  output logic                               rx_parity_err,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic                               rx_overflow,
  output logic [$clog2(RX_FIFO_DEPTH):0]     rx_fifo_count
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = $clog2(DATA_BITS);
  localparam int unsigned AW   = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned EW   = DATA_BITS + 2;

  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   RDY_POINT = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0]   HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]   DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic            PAR_ODD   = 1'(PARITY_ODD);
  localparam logic            PAR_EN    = 1'(PARITY_EN);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(RX_FIFO_DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
  } rx_state_t;

  // ---------------------------------------------------------------- TX
  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic                 tx_stop;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 tx_accept_c;

  assign tx_accept_c = tx_valid && tx_ready;

  // tx_ready is only high in IDLE or the final stop cycle, so acceptance
  // there chains the next frame with no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      uart_tx  <= 1'b1;
      tx_ready <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
    end else if (tx_accept_c) begin
      tx_state <= TX_START;
      uart_tx  <= 1'b0;
      tx_ready <= 1'b0;
      tx_cnt   <= '0;
      tx_shreg <= tx_data;
      tx_par   <= (^tx_data) ^ PAR_ODD;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: tx_cnt <= '0;
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= tx_shreg[0];
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == DATA_LAST) begin
              tx_stop <= 1'b0;
              if (PAR_EN) begin
                uart_tx  <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                uart_tx  <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shreg <= tx_shreg >> 1;
              uart_tx  <= tx_shreg[1];
            end
          end
        end
        TX_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            uart_tx  <= 1'b1;
            tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_stop == STOP_LAST && tx_cnt == RDY_POINT) tx_ready <= 1'b1;
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_stop == STOP_LAST) tx_state <= TX_IDLE;
            else                      tx_stop  <= 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic                 rx_meta;
  logic                 rx_sync;
  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_perr;
  logic                 push_c;
  logic [EW-1:0]        push_entry_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // The first stop sample is the push point; its level is the frame flag.
  assign push_c       = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
  assign push_entry_c = {rx_perr, ~rx_sync, rx_shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
      rx_perr  <= 1'b0;
    end else begin
      rx_cnt <= rx_cnt + 1'b1;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt  <= '0;
          rx_perr <= 1'b0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_BIT) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
            if (rx_bit == DATA_LAST) rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
            else                     rx_bit   <= rx_bit + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_perr  <= (^rx_shreg) ^ rx_sync ^ PAR_ODD;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_WAIT_IDLE;
          end
        end
        RX_WAIT_IDLE: begin
          rx_cnt <= '0;
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [EW-1:0]   mem [RX_FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [EW-1:0]   rx_head;
  logic            full_c;
  logic            pop_c;
  logic            wr_c;
  logic [CNTW-1:0] count_next_c;

  always_comb begin
    full_c       = (rx_fifo_count == FULL_CNT);
    pop_c        = rx_valid && rx_ready;
    wr_c         = push_c && (!full_c || pop_c);
    count_next_c = CNTW'(rx_fifo_count + CNTW'(wr_c) - CNTW'(pop_c));
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= push_entry_c;
  end

  // The head register holds its last value once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rx_fifo_count <= '0;
      rx_valid      <= 1'b0;
      rx_overflow   <= 1'b0;
      rx_head       <= '0;
    end else begin
      if (wr_c)  wr_ptr <= AW'(wr_ptr + 1'b1);
      if (pop_c) rd_ptr <= AW'(rd_ptr + 1'b1);
      rx_fifo_count <= count_next_c;
      rx_valid      <= (count_next_c != '0);
      rx_overflow   <= push_c && full_c && !pop_c;
      if (pop_c) begin
        if (rx_fifo_count > CNTW'(1)) rx_head <= mem[AW'(rd_ptr + 1'b1)];
        else if (wr_c)                rx_head <= push_entry_c;
      end else if (rx_fifo_count == '0 && wr_c) begin
        rx_head <= push_entry_c;
      end
    end
  end

  assign rx_data       = rx_head[DATA_BITS-1:0];
  assign rx_frame_err  = rx_head[DATA_BITS];
  assign rx_parity_err = rx_head[DATA_BITS+1];

endmodule
